// File: rtl/cam_line_packer_pkg.sv
// Shared constants and state encoding for the camera line packer and the UDP line transmitter.
package cam_line_packer_pkg;

    localparam int unsigned BYTES_PER_PX = 2;
    localparam int unsigned DEF_IMG_W    = 640;
    localparam int unsigned LINE_BYTES   = DEF_IMG_W * BYTES_PER_PX;
    localparam logic [7:0]  PAD_BYTE     = 8'h00;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LO,
        S_HI,
        S_PAD,
        S_DROP,
        S_TRUNC
    } state_e;

endpackage

// File: rtl/cam_line_packer.sv
// Serialises 16-bit pixels into the 8-bit source FIFO, low byte first, emitting only whole
// lines of exactly LINE_BYTES bytes (admission check, padding of short lines, truncation).
module cam_line_packer
    import cam_line_packer_pkg::*;
#(
    parameter int unsigned IMG_W        = cam_line_packer_pkg::DEF_IMG_W,
    parameter int unsigned BYTES_PER_PX = cam_line_packer_pkg::BYTES_PER_PX,
    parameter int unsigned LINE_BYTES   = IMG_W * BYTES_PER_PX,
    parameter int unsigned FIFO_DEPTH   = 4096,
    parameter logic [7:0]  PAD_BYTE     = cam_line_packer_pkg::PAD_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sol,
    output logic        pix_ready,
    output logic [7:0]  fifo_din,
    output logic        fifo_wr,
    input  logic        fifo_full,
    input  logic [15:0] fifo_wrusedw,
    output logic [15:0] dbg_drop_cnt,
    output logic [15:0] dbg_pad_cnt,
    output logic [15:0] dbg_trunc_cnt,
    output logic        dbg_ovf
);

    localparam logic [16:0] DEPTH17    = 17'(FIFO_DEPTH);
    localparam logic [16:0] LINE_B17   = 17'(LINE_BYTES);
    localparam logic [15:0] LINE_B16   = 16'(LINE_BYTES);
    localparam logic [15:0] LAST_PX    = 16'(IMG_W);

    state_e      state_q, state_d;
    logic [15:0] pix_q, pix_d;
    logic [15:0] px_cnt_q, px_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic        hi_done_q, hi_done_d;
    logic        trunc_seen_q, trunc_seen_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [7:0]  fifo_din_q, fifo_din_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] pad_cnt_q, pad_cnt_d;
    logic [15:0] trunc_cnt_q, trunc_cnt_d;
    logic        ovf_q, ovf_d;

    logic [16:0] free_bytes;
    logic        admit;
    logic [15:0] px_next;
    logic        hi_open;

    // Guard against a used count above depth so the subtraction cannot wrap to a huge value.
    always_comb begin
        if (17'(fifo_wrusedw) > DEPTH17) begin
            free_bytes = '0;
        end else begin
            free_bytes = DEPTH17 - 17'(fifo_wrusedw);
        end
        admit   = (free_bytes >= LINE_B17);
        px_next = px_cnt_q + 16'd1;
    end

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        px_cnt_d     = px_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        hi_done_d    = hi_done_q;
        trunc_seen_d = trunc_seen_q;
        fifo_wr_d    = 1'b0;
        fifo_din_d   = fifo_din_q;
        drop_cnt_d   = drop_cnt_q;
        pad_cnt_d    = pad_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        ovf_d        = ovf_q;
        pix_ready    = 1'b0;
        hi_open      = 1'b0;

        unique case (state_q)
            S_SYNC: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_sol) begin
                    if (admit) begin
                        pix_d        = pix_data;
                        px_cnt_d     = '0;
                        byte_cnt_d   = '0;
                        trunc_seen_d = 1'b0;
                        state_d      = S_LO;
                    end else begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        state_d    = S_DROP;
                    end
                end
            end
            S_LO: begin
                if (fifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    fifo_wr_d  = 1'b1;
                    fifo_din_d = pix_q[7:0];
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    hi_done_d  = 1'b0;
                    state_d    = S_HI;
                end
            end
            S_HI: begin
                hi_open = hi_done_q;
                if (!hi_done_q) begin
                    if (fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        fifo_wr_d  = 1'b1;
                        fifo_din_d = pix_q[15:8];
                        byte_cnt_d = byte_cnt_q + 16'd1;
                        px_cnt_d   = px_next;
                        hi_done_d  = 1'b1;
                        if (px_next == LAST_PX) begin
                            state_d = S_TRUNC;
                        end else begin
                            hi_open = 1'b1;
                        end
                    end
                end
                // A sol pixel here ends a short line; it is left pending for S_SYNC.
                if (hi_open) begin
                    pix_ready = !(pix_valid && pix_sol);
                    if (pix_valid) begin
                        if (pix_sol) begin
                            state_d = S_PAD;
                        end else begin
                            pix_d   = pix_data;
                            state_d = S_LO;
                        end
                    end
                end
            end
            S_PAD: begin
                if (byte_cnt_q == LINE_B16) begin
                    pad_cnt_d = pad_cnt_q + 16'd1;
                    state_d   = S_SYNC;
                end else if (fifo_full) begin
                    ovf_d = 1'b1;
                end else begin
                    fifo_wr_d  = 1'b1;
                    fifo_din_d = PAD_BYTE;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                end
            end
            S_TRUNC: begin
                pix_ready = !(pix_valid && pix_sol);
                if (pix_valid) begin
                    if (pix_sol) begin
                        state_d = S_SYNC;
                    end else if (!trunc_seen_q) begin
                        trunc_cnt_d  = trunc_cnt_q + 16'd1;
                        trunc_seen_d = 1'b1;
                    end
                end
            end
            S_DROP: begin
                pix_ready = !(pix_valid && pix_sol);
                if (pix_valid && pix_sol) begin
                    state_d = S_SYNC;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (rst) begin
            pix_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SYNC;
            pix_q        <= '0;
            px_cnt_q     <= '0;
            byte_cnt_q   <= '0;
            hi_done_q    <= 1'b0;
            trunc_seen_q <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_din_q   <= '0;
            drop_cnt_q   <= '0;
            pad_cnt_q    <= '0;
            trunc_cnt_q  <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            px_cnt_q     <= px_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            hi_done_q    <= hi_done_d;
            trunc_seen_q <= trunc_seen_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_din_q   <= fifo_din_d;
            drop_cnt_q   <= drop_cnt_d;
            pad_cnt_q    <= pad_cnt_d;
            trunc_cnt_q  <= trunc_cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign fifo_wr       = fifo_wr_q;
    assign fifo_din      = fifo_din_q;
    assign dbg_drop_cnt  = drop_cnt_q;
    assign dbg_pad_cnt   = pad_cnt_q;
    assign dbg_trunc_cnt = trunc_cnt_q;
    assign dbg_ovf       = ovf_q;

endmodule

// File: tb/tb_cam_line_packer.sv
// Scoreboard bench for cam_line_packer: expected FIFO bytes are queued as pixels are accepted
// and compared as writes appear.
module tb_cam_line_packer;
    import cam_line_packer_pkg::*;

    localparam int unsigned IMG_W      = 640;
    localparam int unsigned FIFO_DEPTH = 4096;
    localparam int unsigned LB         = IMG_W * 2;

    logic        clk;
    logic        rst;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_sol;
    logic        pix_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr;
    logic        fifo_full;
    logic [15:0] fifo_wrusedw;
    logic [15:0] dbg_drop_cnt;
    logic [15:0] dbg_pad_cnt;
    logic [15:0] dbg_trunc_cnt;
    logic        dbg_ovf;

    cam_line_packer #(
        .IMG_W      (IMG_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_sol       (pix_sol),
        .pix_ready     (pix_ready),
        .fifo_din      (fifo_din),
        .fifo_wr       (fifo_wr),
        .fifo_full     (fifo_full),
        .fifo_wrusedw  (fifo_wrusedw),
        .dbg_drop_cnt  (dbg_drop_cnt),
        .dbg_pad_cnt   (dbg_pad_cnt),
        .dbg_trunc_cnt (dbg_trunc_cnt),
        .dbg_ovf       (dbg_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int checks = 0;
    int fails  = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got byte %02h, required no write", fifo_din);
            end else begin
                exp_b = exp_q.pop_front();
                if (fifo_din !== exp_b) begin
                    fails++;
                    $display("FAIL wr_data (write #%0d): got %02h, required %02h",
                             wr_cnt, fifo_din, exp_b);
                end
            end
        end
    end

    task automatic drive_pix(input logic [15:0] d, input logic sol, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sol   = sol;
        for (int n = 0; n < 4000; n++) begin
            #1;
            if (pix_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL pix_handshake_timeout: got no pix_ready, required acceptance of %04h",
                     d);
        end
    endtask

    task automatic send_line(input int n, input bit admit, input bit with_sol);
        logic        ok;
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = 16'h1234 + 16'(i);
            drive_pix(d, with_sol && (i == 0), ok);
            if (ok && admit && (i < IMG_W)) begin
                exp_q.push_back(d[7:0]);
                exp_q.push_back(d[15:8]);
            end
        end
        if (admit && (n < IMG_W)) begin
            for (int p = 0; p < (IMG_W - n) * 2; p++) exp_q.push_back(PAD_BYTE);
        end
        #1;
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d bytes still expected, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        pix_valid    = 1'b0;
        pix_sol      = 1'b0;
        pix_data     = '0;
        fifo_full    = 1'b0;
        fifo_wrusedw = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pix_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b, required 0", pix_ready);
        end
        checks++;
        if ({fifo_wr, fifo_din} !== 9'h000) begin
            fails++;
            $display("FAIL reset_fifo: got wr=%b din=%02h, required 0/00", fifo_wr, fifo_din);
        end
        checks++;
        if ({dbg_drop_cnt, dbg_pad_cnt, dbg_trunc_cnt, dbg_ovf} !== 49'h0) begin
            fails++;
            $display("FAIL reset_dbg: got %0d/%0d/%0d/%b, required 0/0/0/0",
                     dbg_drop_cnt, dbg_pad_cnt, dbg_trunc_cnt, dbg_ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b, required 1", pix_ready);
        end
    endtask

    task automatic test_full_lines();
        int w0;
        w0 = wr_cnt;
        send_line(IMG_W, 1'b1, 1'b1);
        send_line(IMG_W, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (wr_cnt - w0 != 2 * LB) begin
            fails++;
            $display("FAIL full_lines_count: got %0d writes, required %0d", wr_cnt - w0, 2 * LB);
        end
        checks++;
        if ({dbg_drop_cnt, dbg_pad_cnt, dbg_trunc_cnt, dbg_ovf} !== 49'h0) begin
            fails++;
            $display("FAIL full_lines_dbg: got %0d/%0d/%0d/%b, required 0/0/0/0",
                     dbg_drop_cnt, dbg_pad_cnt, dbg_trunc_cnt, dbg_ovf);
        end
    endtask

    task automatic test_drop();
        int w0;
        w0 = wr_cnt;
        fifo_wrusedw = 16'(FIFO_DEPTH - (LB - 1));
        send_line(IMG_W, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt != w0) begin
            fails++;
            $display("FAIL drop_writes: got %0d writes, required 0", wr_cnt - w0);
        end
        checks++;
        if (dbg_drop_cnt !== 16'd1) begin
            fails++;
            $display("FAIL drop_cnt: got %0d, required 1", dbg_drop_cnt);
        end
        fifo_wrusedw = '0;
        w0 = wr_cnt;
        send_line(IMG_W, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (wr_cnt - w0 != LB) begin
            fails++;
            $display("FAIL drop_next_line: got %0d writes, required %0d", wr_cnt - w0, LB);
        end
    endtask

    task automatic test_pad();
        int w0;
        w0 = wr_cnt;
        send_line(600, 1'b1, 1'b1);
        send_line(IMG_W, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (wr_cnt - w0 != 2 * LB) begin
            fails++;
            $display("FAIL pad_count: got %0d writes, required %0d", wr_cnt - w0, 2 * LB);
        end
        checks++;
        if (dbg_pad_cnt !== 16'd1) begin
            fails++;
            $display("FAIL pad_cnt: got %0d, required 1", dbg_pad_cnt);
        end
    endtask

    task automatic test_trunc();
        int w0;
        w0 = wr_cnt;
        send_line(650, 1'b1, 1'b1);
        checks++;
        if (dbg_trunc_cnt !== 16'd1) begin
            fails++;
            $display("FAIL trunc_cnt: got %0d, required 1", dbg_trunc_cnt);
        end
        send_line(IMG_W, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (wr_cnt - w0 != 2 * LB) begin
            fails++;
            $display("FAIL trunc_count: got %0d writes, required %0d", wr_cnt - w0, 2 * LB);
        end
        checks++;
        if (dbg_trunc_cnt !== 16'd1) begin
            fails++;
            $display("FAIL trunc_cnt_after_full: got %0d, required 1", dbg_trunc_cnt);
        end
    endtask

    task automatic test_fifo_full();
        int w0;
        w0 = wr_cnt;
        fork
            send_line(IMG_W, 1'b1, 1'b1);
            begin
                repeat (200) @(negedge clk);
                fifo_full = 1'b1;
                repeat (5) @(negedge clk);
                fifo_full = 1'b0;
            end
        join
        wait_drain();
        checks++;
        if (wr_cnt - w0 != LB) begin
            fails++;
            $display("FAIL full_stall_count: got %0d writes, required %0d", wr_cnt - w0, LB);
        end
        checks++;
        if (dbg_ovf !== 1'b1) begin
            fails++;
            $display("FAIL full_stall_ovf: got %b, required 1", dbg_ovf);
        end
    endtask

    task automatic test_rst_mid_line();
        int          w0;
        logic        ok;
        logic [15:0] d;
        w0 = wr_cnt;
        for (int i = 0; i < 300; i++) begin
            d = 16'h1234 + 16'(i);
            drive_pix(d, i == 0, ok);
            if (ok) begin
                exp_q.push_back(d[7:0]);
                exp_q.push_back(d[15:8]);
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sol   = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_cnt - w0 != 598 || exp_q.size() != 2) begin
            fails++;
            $display("FAIL rst_partial: got %0d writes/%0d pending, required 598/2",
                     wr_cnt - w0, exp_q.size());
        end
        exp_q.delete();
        checks++;
        if ({pix_ready, fifo_wr, fifo_din} !== 10'h000) begin
            fails++;
            $display("FAIL rst_outputs: got ready=%b wr=%b din=%02h, required 0/0/00",
                     pix_ready, fifo_wr, fifo_din);
        end
        checks++;
        if ({dbg_drop_cnt, dbg_pad_cnt, dbg_trunc_cnt, dbg_ovf} !== 49'h0) begin
            fails++;
            $display("FAIL rst_dbg: got %0d/%0d/%0d/%b, required 0/0/0/0",
                     dbg_drop_cnt, dbg_pad_cnt, dbg_trunc_cnt, dbg_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        w0  = wr_cnt;
        for (int i = 0; i < 20; i++) drive_pix(16'hdead, 1'b0, ok);
        send_line(IMG_W, 1'b1, 1'b1);
        wait_drain();
        checks++;
        if (wr_cnt - w0 != LB) begin
            fails++;
            $display("FAIL rst_next_line: got %0d writes, required %0d", wr_cnt - w0, LB);
        end
    endtask

    initial begin
        test_reset();
        test_full_lines();
        test_drop();
        test_pad();
        test_trunc();
        test_fifo_full();
        test_rst_mid_line();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
